// File: rtl/numero_scan.sv
// numero_scan: captures N BCD digits into a shadow register and scans them
// onto a single 7-segment bus with a one-hot digit enable, an invalid-digit
// flag, optional leading-zero blanking and selectable output polarity.
module numero_scan #(
  parameter int N_DIGITS   = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ready,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic                    blank_lz,
  output logic                    ack,
  output logic [6:0]              seg,
  output logic [N_DIGITS-1:0]     an,
  output logic                    err
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N_DIGITS - 1);
  localparam bit            INV     = (ACTIVE_LOW != 0);
  localparam logic [6:0]    SEG_OFF = INV ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF = INV ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};

  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [PW-1:0]         pre_q, pre_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;

  logic [N_DIGITS-1:0]   nz_above;
  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [6:0]            raw_seg;
  logic [N_DIGITS-1:0]   an_hot;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h40;
    endcase
  endfunction

  // Capture path: shadow, one-cycle ack and the invalid-digit flag.
  always_comb begin
    shadow_d = shadow_q;
    ack_d    = ready;
    err_d    = err_q;
    if (ready) begin
      shadow_d = digits_in;
      err_d    = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        err_d = err_d | (digits_in[4*i +: 4] > 4'd9);
      end
    end
  end

  // Prescaler wraps at SCAN_DIV-1 and advances the digit index on wrap.
  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PRE_MAX) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IW'(1);
    end
  end

  // nz_above[i]: some shadow digit at position i or higher is non-zero.
  always_comb begin
    nz_above = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (i == N_DIGITS - 1) nz_above[i] = (shadow_q[4*i +: 4] != 4'd0);
      else                   nz_above[i] = nz_above[i+1] | (shadow_q[4*i +: 4] != 4'd0);
    end
  end

  // Select the current digit, apply blanking and polarity for the output flops.
  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    an_hot    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_digit = shadow_q[4*i +: 4];
        cur_blank = blank_lz && (i > 0) && !nz_above[i];
        an_hot[i] = 1'b1;
      end
    end
    raw_seg = cur_blank ? 7'h00 : seg_code(cur_digit);
    seg_d   = INV ? ~raw_seg : raw_seg;
    an_d    = INV ? ~an_hot  : an_hot;
  end

  // All state registers; reset drives outputs to their inactive level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_OFF;
      an_q     <= AN_OFF;
    end else begin
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign ack = ack_q;
  assign err = err_q;
  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_numero_scan.sv
// Directed bench for numero_scan with N_DIGITS=4, SCAN_DIV=4, ACTIVE_LOW=1.
module tb_numero_scan;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic        blank_lz = 1'b0;
  logic        ack;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        err;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;   // clock edges since the most recent reset release

  numero_scan #(.N_DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .ready(ready), .digits_in(digits_in),
    .blank_lz(blank_lz), .ack(ack), .seg(seg), .an(an), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  // Runs 16 edges; the slot shown after edge k is ((k-1)/4)%4.
  task automatic scan_check(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    logic [6:0] es;
    logic [3:0] ea;
    int slot;
    for (int c = 0; c < 16; c++) begin
      tick();
      slot = ((k - 1) / 4) % 4;
      case (slot)
        0: begin es = s0; ea = 4'hE; end
        1: begin es = s1; ea = 4'hD; end
        2: begin es = s2; ea = 4'hB; end
        default: begin es = s3; ea = 4'h7; end
      endcase
      chk({tag, "_an"}, {4'h0, an}, {4'h0, ea});
      chk({tag, "_seg"}, {1'b0, seg}, {1'b0, es});
    end
  endtask

  task automatic capture(input string tag, input logic [15:0] val, input logic exp_err);
    ready = 1'b1;
    digits_in = val;
    tick();
    chk({tag, "_ack1"}, {7'h0, ack}, 8'h01);
    chk({tag, "_err"}, {7'h0, err}, {7'h0, exp_err});
    ready = 1'b0;
    tick();
    chk({tag, "_ack0"}, {7'h0, ack}, 8'h00);
  endtask

  initial begin
    // 1. Reset state
    reset = 1'b0;
    tick(); tick();
    chk("rst_seg", {1'b0, seg}, 8'h7F);
    chk("rst_an",  {4'h0, an},  8'h0F);
    chk("rst_ack", {7'h0, ack}, 8'h00);
    chk("rst_err", {7'h0, err}, 8'h00);

    // 2. Basic scan: capture on the first edge after release
    reset = 1'b1;
    k = 0;
    ready = 1'b1;
    digits_in = 16'h4321;
    tick();
    chk("t2_ack1", {7'h0, ack}, 8'h01);
    chk("t2_err",  {7'h0, err}, 8'h00);
    chk("t2_first_an",  {4'h0, an},  8'h0E);
    chk("t2_first_seg", {1'b0, seg}, 8'h40);
    ready = 1'b0;
    tick();
    chk("t2_ack0", {7'h0, ack}, 8'h00);
    chk("t2_seg_new", {1'b0, seg}, 8'h79);
    scan_check("t2", 7'h79, 7'h24, 7'h30, 7'h19);
    scan_check("t2b", 7'h79, 7'h24, 7'h30, 7'h19);

    // 3. Invalid digit
    capture("t3a", 16'h00A5, 1'b1);
    scan_check("t3", 7'h12, 7'h3F, 7'h40, 7'h40);
    capture("t3b", 16'h0005, 1'b0);

    // 4. Leading-zero blanking, live enable
    blank_lz = 1'b1;
    capture("t4a", 16'h0012, 1'b0);
    scan_check("t4_blank", 7'h24, 7'h79, 7'h7F, 7'h7F);
    blank_lz = 1'b0;
    scan_check("t4_noblank", 7'h24, 7'h79, 7'h40, 7'h40);
    blank_lz = 1'b1;
    capture("t4b", 16'h0000, 1'b0);
    scan_check("t4_zero", 7'h40, 7'h7F, 7'h7F, 7'h7F);
    blank_lz = 1'b0;

    // 5. Back-to-back ready: last value wins
    ready = 1'b1;
    digits_in = 16'h1111;
    tick();
    chk("t5_ack_a", {7'h0, ack}, 8'h01);
    digits_in = 16'h9999;
    tick();
    chk("t5_ack_b", {7'h0, ack}, 8'h01);
    ready = 1'b0;
    tick();
    chk("t5_ack_c", {7'h0, ack}, 8'h00);
    chk("t5_err",   {7'h0, err}, 8'h00);
    scan_check("t5", 7'h10, 7'h10, 7'h10, 7'h10);

    // 6. Reset during a capture cycle while index is 2
    for (int i = 0; i < 20; i++) begin
      if (((k / 4) % 4) == 2) break;
      tick();
    end
    ready = 1'b1;
    digits_in = 16'h12A4;
    tick();
    chk("t6_pre_ack", {7'h0, ack}, 8'h01);
    chk("t6_pre_err", {7'h0, err}, 8'h01);
    chk("t6_pre_an",  {4'h0, an},  8'h0B);
    reset = 1'b0;
    #1;
    chk("t6_ack", {7'h0, ack}, 8'h00);
    chk("t6_err", {7'h0, err}, 8'h00);
    chk("t6_seg", {1'b0, seg}, 8'h7F);
    chk("t6_an",  {4'h0, an},  8'h0F);
    tick();
    ready = 1'b0;
    tick();
    chk("t6_hold_an", {4'h0, an}, 8'h0F);
    reset = 1'b1;
    k = 0;
    scan_check("t6_post", 7'h40, 7'h40, 7'h40, 7'h40);
    chk("t6_post_ack", {7'h0, ack}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/numero_scan.md
Name: numero_scan

Overview:
- Parametrised, clocked successor to the team's single-digit combinational number decoder.
- Captures N BCD digits on a ready strobe into a shadow register and converts each digit to a 7-segment code.
- Time-multiplexes the digits onto one segment bus with a one-hot digit enable.
- Adds an invalid-digit error flag, optional leading-zero blanking and selectable output polarity.
- Sits between the datapath producing BCD values and the board display.

Parameters:
N_DIGITS, 4, number of 4-bit digits handled; legal range 1..8.
SCAN_DIV, 1000, clk cycles each digit is shown; legal range >=1; 1 = advance every cycle.
ACTIVE_LOW, 1, 1 = seg and an outputs active-low; 0 = active-high.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset  in  1  asynchronous, active-low reset.
ready  in  1  load strobe; sampled each rising clk edge.
digits_in  in  4*N_DIGITS  BCD digits; digit i = bits [4i+3:4i]; digit 0 is least significant.
blank_lz  in  1  leading-zero blanking enable; level, used live.
ack  out  1  one-cycle pulse confirming a capture.
seg  out  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW.
an  out  N_DIGITS  one-hot digit enable, polarity per ACTIVE_LOW.
err  out  1  high while any captured digit is greater than 9.

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - shadow register to 0, digit index to 0, prescaler to 0;
  - ack=0, err=0;
  - seg and an to their inactive level (all 1s if ACTIVE_LOW=1, all 0s otherwise).
- Release of reset is synchronous to clk. The first display output appears on the first clk edge after release.
- Capture: on a clk edge with ready=1, digits_in is copied into the shadow register. On the same edge:
  - ack goes to 1 for exactly that next cycle;
  - err is set to OR over i of (digit_i > 9), computed from the incoming digits_in.
- ready held high for k cycles gives k captures and k consecutive ack cycles; the last captured value wins. ready=0 leaves shadow and err unchanged.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. On the terminal count the digit index increments, wrapping from N_DIGITS-1 to 0. The index is constant 0 when N_DIGITS=1.
- Outputs are registered every cycle from the current index and shadow. One cycle of latency: seg/an at edge t+1 reflect idx(t) and shadow(t). seg and an always change on the same edge and never disagree.
- an: bit idx asserted, all other bits inactive.
- Segment table, active-high form before polarity is applied:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F;
  - 10..15 = 40 (dash only).
- Leading-zero blanking: digit i (i>0) is blanked when blank_lz=1 and every shadow digit j>=i equals 0.
  - Blanked digit: seg all inactive, an still asserted for its slot.
  - Digit 0 is never blanked.
  - A digit >9 counts as non-zero.
- Capture during a scan does not reset the index or the prescaler. The new value appears on the next registered output.
- Reset asserted mid-scan or mid-capture: all state is cleared immediately and any pending ack is dropped.
- No arithmetic beyond the prescaler (width clog2(SCAN_DIV), minimum 1) and the index (width clog2(N_DIGITS), minimum 1) counters.

Test Plan:
1. Reset check (N=4, SCAN_DIV=4, ACTIVE_LOW=1): hold reset=0, toggle clk -> seg=7F, an=F, ack=0, err=0.
2. Basic scan: release reset, pulse ready with digits_in=16'h4321 -> ack high one cycle, err=0.
   - Outputs then show an=E/seg=~06, an=D/~5B, an=B/~4F, an=7/~66.
   - Each digit is held 4 cycles; the pattern repeats.
3. Invalid digit: capture 16'h00A5 -> err=1.
   - Digit 1 slot shows seg=~40; digit 0 shows ~6D.
   - Recapture 16'h0005 -> err=0 on the ack cycle.
4. Leading-zero blanking: capture 16'h0012 with blank_lz=1 -> slots 3 and 2 show seg=7F (off) with an asserted; slots 1 and 0 show ~06 and ~5B.
   - With blank_lz=0, slots 3 and 2 show ~3F.
   - Capture 16'h0000 -> only digit 0 lit, showing ~3F.
5. Back-to-back ready: ready high 2 cycles with 16'h1111 then 16'h9999 -> ack high 2 cycles; displayed digits all ~6F.
6. Reset mid-operation: assert reset at index 2 during a capture cycle -> outputs inactive within the same cycle, no ack.
   - After release, the display starts at index 0 showing ~3F on all slots (blank_lz=0).
